// File: rtl/cpu_core_seq_if.sv
// cpu_core_seq_if: groups the opcode, data bus, register values, ALU results,
// PC, micro-state and control strobes of the 8-bit bus CPU sequencer.
//
//   opcode   current IR value               (master -> slave)
//   bus_in   shared data bus, jump target   (master -> slave)
//   a_in     A register value               (master -> slave)
//   b_in     B register value               (master -> slave)
//   alu_out  ALU result                     (slave -> master)
//   cout     ALU carry out                  (slave -> master)
//   eq_zero  a_in == 0                      (slave -> master)
//   pc_out   program counter                (slave -> master)
//   state    current micro-state            (slave -> master)
//   cycle    micro-step counter             (slave -> master)
//   c_*      bus control strobes            (slave -> master)
interface cpu_core_seq_if;
    logic [7:0] opcode;
    logic [7:0] bus_in;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic [7:0] alu_out;
    logic       cout;
    logic       eq_zero;
    logic [7:0] pc_out;
    logic [3:0] state;
    logic [3:0] cycle;

    logic c_ai;
    logic c_ao;
    logic c_bi;
    logic c_ci;
    logic c_co;
    logic c_eo;
    logic c_halt;
    logic c_ii;
    logic c_j;
    logic c_mi;
    logic c_oi;
    logic c_ro;
    logic c_ri;

    // Driven by the surrounding datapath / testbench.
    modport master (
        output opcode, bus_in, a_in, b_in,
        input  alu_out, cout, eq_zero, pc_out, state, cycle,
        input  c_ai, c_ao, c_bi, c_ci, c_co, c_eo, c_halt, c_ii, c_j, c_mi, c_oi, c_ro, c_ri
    );

    // Implemented by cpu_core_seq.
    modport slave (
        input  opcode, bus_in, a_in, b_in,
        output alu_out, cout, eq_zero, pc_out, state, cycle,
        output c_ai, c_ao, c_bi, c_ci, c_co, c_eo, c_halt, c_ii, c_j, c_mi, c_oi, c_ro, c_ri
    );
endinterface

// File: rtl/cpu_core_seq.sv
// cpu_core_seq: micro-step sequencer, program counter and add/sub ALU for the
// 8-bit bus CPU. One micro-step per clock. The micro-state is decoded
// combinationally from (opcode, cycle) and drives the bus control strobes that
// external registers, RAM and bus drivers capture on the same clock edge.
//
// Ports:
//   clk    system clock, all updates on the rising edge
//   reset  synchronous, active-low; clears cycle and PC
//   bus    cpu_core_seq_if.slave: opcode/bus_in/a_in/b_in in, ALU, PC,
//          state, cycle and strobes out
module cpu_core_seq (
    input logic          clk,
    input logic          reset,
    cpu_core_seq_if.slave bus
);

    typedef enum logic [3:0] {
        StNext      = 4'd0,
        StFetchPc   = 4'd1,
        StFetchInst = 4'd2,
        StLoadAddr  = 4'd3,
        StRamA      = 4'd4,
        StRamB      = 4'd5,
        StAluOp     = 4'd6,
        StStoreA    = 4'd7,
        StOutA      = 4'd8,
        StJump      = 4'd9,
        StHalt      = 4'd10
    } state_e;

    localparam logic [7:0] OpNop = 8'h00;
    localparam logic [7:0] OpLda = 8'h10;
    localparam logic [7:0] OpAdd = 8'h20;
    localparam logic [7:0] OpSub = 8'h21;
    localparam logic [7:0] OpSta = 8'h30;
    localparam logic [7:0] OpOut = 8'h40;
    localparam logic [7:0] OpJmp = 8'h50;
    localparam logic [7:0] OpJez = 8'h51;
    localparam logic [7:0] OpJnz = 8'h52;
    localparam logic [7:0] OpHlt = 8'hF0;

    logic [3:0] cycle_q, cycle_d;
    logic [7:0] pc_q, pc_d;
    state_e     st;

    logic       eq_zero;
    logic       jump_allowed;
    logic [8:0] alu_sum;
    logic [7:0] alu_b;

    logic c_ai, c_ao, c_bi, c_ci, c_co, c_eo, c_halt;
    logic c_ii, c_j, c_mi, c_oi, c_ro, c_ri;

    // ------------------------------------------------------------------
    // State register: micro-step counter and PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q <= 4'd0;
            pc_q    <= 8'h00;
        end else begin
            cycle_q <= cycle_d;
            pc_q    <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Micro-state decode from (opcode, cycle). Cycles 0 and 1 are the
    // common fetch; the IR only holds the new opcode from cycle 2 on.
    // ------------------------------------------------------------------
    always_comb begin
        st = StNext;
        if (cycle_q == 4'd0) begin
            st = StFetchPc;
        end else if (cycle_q == 4'd1) begin
            st = StFetchInst;
        end else begin
            case (bus.opcode)
                OpNop: st = StNext;
                OpLda: begin
                    case (cycle_q)
                        4'd2:    st = StFetchPc;
                        4'd3:    st = StLoadAddr;
                        4'd4:    st = StRamA;
                        default: st = StNext;
                    endcase
                end
                OpAdd, OpSub: begin
                    case (cycle_q)
                        4'd2:    st = StFetchPc;
                        4'd3:    st = StLoadAddr;
                        4'd4:    st = StRamB;
                        4'd5:    st = StAluOp;
                        default: st = StNext;
                    endcase
                end
                OpSta: begin
                    case (cycle_q)
                        4'd2:    st = StFetchPc;
                        4'd3:    st = StLoadAddr;
                        4'd4:    st = StStoreA;
                        default: st = StNext;
                    endcase
                end
                OpOut: begin
                    case (cycle_q)
                        4'd2:    st = StOutA;
                        default: st = StNext;
                    endcase
                end
                OpJmp, OpJez, OpJnz: begin
                    case (cycle_q)
                        4'd2:    st = StFetchPc;
                        4'd3:    st = StJump;
                        default: st = StNext;
                    endcase
                end
                // Cycle freezes in HALT, so the decode stays here until reset.
                OpHlt:   st = StHalt;
                default: st = StNext;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state: cycle counter and PC
    // ------------------------------------------------------------------
    always_comb begin
        cycle_d = cycle_q + 4'd1;
        if (st == StNext) begin
            cycle_d = 4'd0;
        end else if (st == StHalt) begin
            cycle_d = cycle_q;
        end

        pc_d = pc_q;
        if (c_ci) begin
            // A not-taken jump still increments, skipping the operand byte.
            pc_d = c_j ? bus.bus_in : pc_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Jump condition and ALU
    // ------------------------------------------------------------------
    assign eq_zero = (bus.a_in == 8'h00);

    always_comb begin
        jump_allowed = 1'b0;
        case (bus.opcode)
            OpJmp:   jump_allowed = 1'b1;
            OpJez:   jump_allowed = eq_zero;
            OpJnz:   jump_allowed = ~eq_zero;
            default: jump_allowed = 1'b0;
        endcase
    end

    // opcode[0] selects subtract as a + ~b + 1; cout=1 then means no borrow.
    assign alu_b   = bus.opcode[0] ? ~bus.b_in : bus.b_in;
    assign alu_sum = {1'b0, bus.a_in} + {1'b0, alu_b} + {8'd0, bus.opcode[0]};

    // ------------------------------------------------------------------
    // Output decode: control strobes
    // ------------------------------------------------------------------
    always_comb begin
        c_ai   = 1'b0;
        c_ao   = 1'b0;
        c_bi   = 1'b0;
        c_ci   = 1'b0;
        c_co   = 1'b0;
        c_eo   = 1'b0;
        c_halt = 1'b0;
        c_ii   = 1'b0;
        c_j    = 1'b0;
        c_mi   = 1'b0;
        c_oi   = 1'b0;
        c_ro   = 1'b0;
        c_ri   = 1'b0;
        case (st)
            StFetchPc: begin
                c_co = 1'b1;
                c_mi = 1'b1;
            end
            StFetchInst: begin
                c_ii = 1'b1;
                c_ci = 1'b1;
                c_ro = 1'b1;
            end
            StLoadAddr: begin
                c_mi = 1'b1;
                c_ci = 1'b1;
                c_ro = 1'b1;
            end
            StRamA: begin
                c_ro = 1'b1;
                c_ai = 1'b1;
            end
            StRamB: begin
                c_ro = 1'b1;
                c_bi = 1'b1;
            end
            StAluOp: begin
                c_ai = 1'b1;
                c_eo = 1'b1;
            end
            StStoreA: begin
                c_ao = 1'b1;
                c_ri = 1'b1;
            end
            StOutA: begin
                c_ao = 1'b1;
                c_oi = 1'b1;
            end
            StJump: begin
                c_ci = 1'b1;
                c_ro = jump_allowed;
                c_j  = jump_allowed;
            end
            StHalt:  c_halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.alu_out = alu_sum[7:0];
    assign bus.cout    = alu_sum[8];
    assign bus.eq_zero = eq_zero;
    assign bus.pc_out  = pc_q;
    assign bus.state   = st;
    assign bus.cycle   = cycle_q;

    assign bus.c_ai   = c_ai;
    assign bus.c_ao   = c_ao;
    assign bus.c_bi   = c_bi;
    assign bus.c_ci   = c_ci;
    assign bus.c_co   = c_co;
    assign bus.c_eo   = c_eo;
    assign bus.c_halt = c_halt;
    assign bus.c_ii   = c_ii;
    assign bus.c_j    = c_j;
    assign bus.c_mi   = c_mi;
    assign bus.c_oi   = c_oi;
    assign bus.c_ro   = c_ro;
    assign bus.c_ri   = c_ri;

endmodule

// File: tb/tb_cpu_core_seq.sv
// tb_cpu_core_seq: directed testbench for cpu_core_seq. Each task runs one
// scenario from cycle 0 and compares against hand-computed values.
module tb_cpu_core_seq;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    cpu_core_seq_if bif ();

    cpu_core_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Strobe vector, MSB first: ai ao bi ci co eo halt ii j mi oi ro ri
    logic [12:0] strb;
    assign strb = {bif.c_ai, bif.c_ao, bif.c_bi, bif.c_ci, bif.c_co, bif.c_eo, bif.c_halt,
                   bif.c_ii, bif.c_j, bif.c_mi, bif.c_oi, bif.c_ro, bif.c_ri};

    localparam logic [12:0] S_AI = 13'h1000, S_AO = 13'h0800, S_BI = 13'h0400;
    localparam logic [12:0] S_CI = 13'h0200, S_CO = 13'h0100, S_EO = 13'h0080;
    localparam logic [12:0] S_HALT = 13'h0040, S_II = 13'h0020, S_J = 13'h0010;
    localparam logic [12:0] S_MI = 13'h0008, S_OI = 13'h0004, S_RO = 13'h0002;
    localparam logic [12:0] S_RI = 13'h0001;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bif.opcode = 8'h00; bif.bus_in = 8'h00; bif.a_in = 8'h00; bif.b_in = 8'h00;
        step(1);
        tests++; if (bif.cycle !== 4'd0) begin fails++; $display("FAIL reset_cycle got %h exp 0", bif.cycle); end
        tests++; if (bif.pc_out !== 8'h00) begin fails++; $display("FAIL reset_pc got %h exp 00", bif.pc_out); end
        tests++; if (bif.state !== 4'd1) begin fails++; $display("FAIL reset_state got %h exp 1", bif.state); end
        tests++; if (strb !== (S_CO | S_MI)) begin fails++; $display("FAIL reset_strb got %h exp %h", strb, S_CO | S_MI); end
        reset = 1'b1;
        step(1);
        tests++; if (bif.cycle !== 4'd1 || bif.state !== 4'd2 || bif.pc_out !== 8'h00) begin
            fails++; $display("FAIL fetch_inst cyc %h st %h pc %h exp 1 2 00", bif.cycle, bif.state, bif.pc_out); end
        tests++; if (strb !== (S_II | S_CI | S_RO)) begin fails++; $display("FAIL fetch_inst_strb got %h exp %h", strb, S_II | S_CI | S_RO); end
        step(1);
        tests++; if (bif.cycle !== 4'd2 || bif.state !== 4'd0 || bif.pc_out !== 8'h01) begin
            fails++; $display("FAIL nop_next cyc %h st %h pc %h exp 2 0 01", bif.cycle, bif.state, bif.pc_out); end
        step(1);
        tests++; if (bif.cycle !== 4'd0) begin fails++; $display("FAIL nop_wrap_cycle got %h exp 0", bif.cycle); end
    endtask

    task automatic test_add_sub;
        // pc = 01 on entry
        bif.opcode = 8'h20; bif.a_in = 8'h7F; bif.b_in = 8'h01;
        step(4);
        tests++; if (bif.state !== 4'd5 || strb !== (S_RO | S_BI)) begin
            fails++; $display("FAIL ram_b st %h strb %h exp 5 %h", bif.state, strb, S_RO | S_BI); end
        step(1);
        tests++; if (bif.alu_out !== 8'h80 || bif.cout !== 1'b0) begin
            fails++; $display("FAIL add_7f_01 got %h/%b exp 80/0", bif.alu_out, bif.cout); end
        tests++; if (strb !== (S_AI | S_EO)) begin fails++; $display("FAIL add_strb got %h exp %h", strb, S_AI | S_EO); end
        step(2);
        tests++; if (bif.cycle !== 4'd0 || bif.pc_out !== 8'h03) begin
            fails++; $display("FAIL add_end cyc %h pc %h exp 0 03", bif.cycle, bif.pc_out); end
        bif.a_in = 8'hFF; bif.b_in = 8'h02;
        step(5);
        tests++; if (bif.alu_out !== 8'h01 || bif.cout !== 1'b1) begin
            fails++; $display("FAIL add_ff_02 got %h/%b exp 01/1", bif.alu_out, bif.cout); end
        step(2);
        bif.opcode = 8'h21; bif.a_in = 8'h05; bif.b_in = 8'h07;
        step(5);
        tests++; if (bif.alu_out !== 8'hFE || bif.cout !== 1'b0) begin
            fails++; $display("FAIL sub_05_07 got %h/%b exp FE/0", bif.alu_out, bif.cout); end
        tests++; if (bif.state !== 4'd6 || strb !== (S_AI | S_EO)) begin
            fails++; $display("FAIL sub_aluop st %h strb %h exp 6 %h", bif.state, strb, S_AI | S_EO); end
        step(2);
        tests++; if (bif.cycle !== 4'd0 || bif.pc_out !== 8'h07) begin
            fails++; $display("FAIL sub_end cyc %h pc %h exp 0 07", bif.cycle, bif.pc_out); end
    endtask

    task automatic test_jump;
        // JMP 0x40, pc = 07 on entry
        bif.opcode = 8'h50; bif.bus_in = 8'h40;
        step(3);
        tests++; if (bif.state !== 4'd9 || strb !== (S_CI | S_RO | S_J)) begin
            fails++; $display("FAIL jmp_state st %h strb %h exp 9 %h", bif.state, strb, S_CI | S_RO | S_J); end
        step(1);
        tests++; if (bif.pc_out !== 8'h40 || bif.state !== 4'd0) begin
            fails++; $display("FAIL jmp_pc pc %h st %h exp 40 0", bif.pc_out, bif.state); end
        step(1);
        // JEZ with A != 0: not taken, skip operand
        bif.opcode = 8'h51; bif.a_in = 8'h03; bif.bus_in = 8'h77;
        step(3);
        tests++; if (strb !== S_CI || bif.pc_out !== 8'h41) begin
            fails++; $display("FAIL jez_nt strb %h pc %h exp %h 41", strb, bif.pc_out, S_CI); end
        step(1);
        tests++; if (bif.pc_out !== 8'h42) begin fails++; $display("FAIL jez_nt_pc got %h exp 42", bif.pc_out); end
        step(1);
        // JNZ with A != 0: taken
        bif.opcode = 8'h52; bif.bus_in = 8'h90;
        step(3);
        tests++; if (strb !== (S_CI | S_RO | S_J)) begin fails++; $display("FAIL jnz_strb got %h exp %h", strb, S_CI | S_RO | S_J); end
        step(1);
        tests++; if (bif.pc_out !== 8'h90) begin fails++; $display("FAIL jnz_pc got %h exp 90", bif.pc_out); end
        step(1);
        // JEZ with A == 0: taken
        bif.opcode = 8'h51; bif.a_in = 8'h00; bif.bus_in = 8'h20;
        tests++; if (bif.eq_zero !== 1'b1) begin fails++; $display("FAIL eq_zero got %b exp 1", bif.eq_zero); end
        step(3);
        tests++; if (strb !== (S_CI | S_RO | S_J)) begin fails++; $display("FAIL jez_t_strb got %h exp %h", strb, S_CI | S_RO | S_J); end
        step(1);
        tests++; if (bif.pc_out !== 8'h20) begin fails++; $display("FAIL jez_t_pc got %h exp 20", bif.pc_out); end
        step(1);
    endtask

    task automatic test_pc_wrap;
        bif.opcode = 8'h50; bif.bus_in = 8'hFF;
        step(4);
        tests++; if (bif.pc_out !== 8'hFF) begin fails++; $display("FAIL wrap_jmp got %h exp FF", bif.pc_out); end
        step(1);
        bif.opcode = 8'h00;
        step(2);
        tests++; if (bif.pc_out !== 8'h00 || bif.state !== 4'd0) begin
            fails++; $display("FAIL wrap_pc pc %h st %h exp 00 0", bif.pc_out, bif.state); end
        step(1);
        tests++; if (bif.cycle !== 4'd0) begin fails++; $display("FAIL wrap_cycle got %h exp 0", bif.cycle); end
    endtask

    task automatic test_mem_ops;
        int hits;
        int hit_cyc;
        // LDA, pc = 00 on entry
        bif.opcode = 8'h10;
        step(3);
        tests++; if (bif.state !== 4'd3 || strb !== (S_MI | S_CI | S_RO)) begin
            fails++; $display("FAIL lda_load_addr st %h strb %h exp 3 %h", bif.state, strb, S_MI | S_CI | S_RO); end
        step(1);
        tests++; if (bif.state !== 4'd4 || strb !== (S_RO | S_AI)) begin
            fails++; $display("FAIL lda_ram_a st %h strb %h exp 4 %h", bif.state, strb, S_RO | S_AI); end
        step(2);
        tests++; if (bif.cycle !== 4'd0 || bif.pc_out !== 8'h02) begin
            fails++; $display("FAIL lda_end cyc %h pc %h exp 0 02", bif.cycle, bif.pc_out); end
        // STA: c_ao and c_ri together only in cycle 4
        bif.opcode = 8'h30;
        hits = 0; hit_cyc = -1;
        for (int i = 0; i < 6; i++) begin
            if (bif.c_ao && bif.c_ri) begin hits++; hit_cyc = i; end
            step(1);
        end
        tests++; if (hits !== 1 || hit_cyc !== 4) begin
            fails++; $display("FAIL sta_store hits %0d at %0d exp 1 at 4", hits, hit_cyc); end
        // OUT: c_oi for one clock
        bif.opcode = 8'h40;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            if (bif.c_oi) hits++;
            step(1);
        end
        tests++; if (hits !== 1 || bif.cycle !== 4'd0 || bif.pc_out !== 8'h05) begin
            fails++; $display("FAIL out_oi hits %0d cyc %h pc %h exp 1 0 05", hits, bif.cycle, bif.pc_out); end
    endtask

    task automatic test_halt;
        bif.opcode = 8'hF0;
        step(2);
        tests++; if (bif.state !== 4'd10 || strb !== S_HALT || bif.pc_out !== 8'h06) begin
            fails++; $display("FAIL halt_enter st %h strb %h pc %h exp A %h 06", bif.state, strb, bif.pc_out, S_HALT); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            tests++; if (bif.cycle !== 4'd2 || bif.state !== 4'd10) begin
                fails++; $display("FAIL halt_hold cyc %h st %h exp 2 A", bif.cycle, bif.state); end
        end
        reset = 1'b0;
        step(1);
        tests++; if (bif.cycle !== 4'd0 || bif.pc_out !== 8'h00 || bif.state !== 4'd1) begin
            fails++; $display("FAIL halt_reset cyc %h pc %h st %h exp 0 00 1", bif.cycle, bif.pc_out, bif.state); end
        reset = 1'b1;
    endtask

    task automatic test_back_to_back;
        // reset mid-ADD, then NOP followed directly by OUT
        bif.opcode = 8'h20;
        step(4);
        reset = 1'b0;
        step(1);
        tests++; if (bif.cycle !== 4'd0 || bif.pc_out !== 8'h00) begin
            fails++; $display("FAIL mid_reset cyc %h pc %h exp 0 00", bif.cycle, bif.pc_out); end
        reset = 1'b1;
        bif.opcode = 8'h00;
        step(3);
        tests++; if (bif.cycle !== 4'd0 || bif.pc_out !== 8'h01) begin
            fails++; $display("FAIL b2b_nop cyc %h pc %h exp 0 01", bif.cycle, bif.pc_out); end
        bif.opcode = 8'h40;
        step(2);
        tests++; if (bif.state !== 4'd8 || strb !== (S_AO | S_OI) || bif.pc_out !== 8'h02) begin
            fails++; $display("FAIL b2b_out st %h strb %h pc %h exp 8 %h 02", bif.state, strb, bif.pc_out, S_AO | S_OI); end
        step(2);
        tests++; if (bif.cycle !== 4'd0) begin fails++; $display("FAIL b2b_end cyc %h exp 0", bif.cycle); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_jump();
        test_pc_wrap();
        test_mem_ops();
        test_halt();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
